spi_pixel_master: RTL and testbench

SPI initiator that streams one pixel word into the grayscale/Sobel core's SPI slave and captures the processed pixel returned on the same transaction. It is the host-side counterpart of the chip's SPI pixel interface, used in the FPGA bring-up bridge and as the bench driver. Each accepted request produces one full-duplex frame. On completion, it captures the received word and optionally pulses the core's pixel-ready input.

---
 rtl/spi_pixel_master.sv | 155 +++++++++++++++
 tb/tb_spi_pixel_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_master.sv
// SPI mode-0 initiator: one full-duplex PIXEL_BITS frame per accepted request, MSB first.
// Define SPI_MASTER_PXRDY_EN to emit a registered px_rdy_o pulse the cycle after done_o.
module spi_pixel_master #(
   parameter int unsigned PIXEL_BITS = 24,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic                  start_i,
   input  logic [PIXEL_BITS-1:0] tx_px_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [PIXEL_BITS-1:0] rx_px_o,
   output logic                  spi_sck_o,
   output logic                  spi_cs_o,
   output logic                  spi_sdo_o,
   input  logic                  spi_sdi_i,
   output logic                  px_rdy_o
);

   localparam int unsigned   BW       = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
   localparam logic [7:0]    PH_LAST  = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(PIXEL_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            ph_q, ph_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  hi_q, hi_d;
   logic                  ph_end;
   logic [PIXEL_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [PIXEL_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [PIXEL_BITS-1:0] rx_px_q, rx_px_d;
   logic                  sck_q, sck_d;
   logic                  cs_q, cs_d;
   logic                  sdo_q, sdo_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  px_rdy_q, px_rdy_d;

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q  <= ST_IDLE;
         ph_q     <= '0;
         bit_q    <= '0;
         hi_q     <= 1'b0;
         tx_sr_q  <= '0;
         rx_sr_q  <= '0;
         rx_px_q  <= '0;
         sck_q    <= 1'b0;
         cs_q     <= 1'b1;
         sdo_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         px_rdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         hi_q     <= hi_d;
         tx_sr_q  <= tx_sr_d;
         rx_sr_q  <= rx_sr_d;
         rx_px_q  <= rx_px_d;
         sck_q    <= sck_d;
         cs_q     <= cs_d;
         sdo_q    <= sdo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         px_rdy_q <= px_rdy_d;
      end
   end

   // Every non-idle state is CLK_DIV cycles long; SHIFT splits each bit into a high and a low phase.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      hi_d    = hi_q;
      ph_end  = (ph_q == PH_LAST);
      if (state_q != ST_IDLE) begin
         ph_d = ph_end ? '0 : ph_q + 8'd1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SETUP;
               ph_d    = '0;
               bit_d   = '0;
               hi_d    = 1'b1;
            end
         end
         ST_SETUP: if (ph_end) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (ph_end) begin
               if (hi_q) begin
                  hi_d = 1'b0;
               end else if (bit_q == BIT_LAST) begin
                  state_d = ST_HOLD;
               end else begin
                  bit_d = bit_q + BW'(1);
                  hi_d  = 1'b1;
               end
            end
         end
         ST_HOLD: if (ph_end) state_d = ST_GAP;
         ST_GAP:  if (ph_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the current state and registered, so pins trail the FSM by one
   // cycle; shifts key off the sck_d/sck_q pair so data moves on the same edge as the pin.
   always_comb begin
      sck_d   = (state_q == ST_SHIFT) && hi_q;
      cs_d    = !(state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      busy_d  = (state_q != ST_IDLE);
      done_d  = (state_q == ST_GAP) && (ph_q == '0);
      tx_sr_d = tx_sr_q;
      rx_sr_d = rx_sr_q;
      rx_px_d = rx_px_q;
      if ((state_q == ST_IDLE) && start_i) begin
         tx_sr_d = tx_px_i;
      end else if (sck_q && !sck_d && (bit_q != BIT_LAST)) begin
         tx_sr_d = {tx_sr_q[PIXEL_BITS-2:0], 1'b0};
      end
      if (sck_d && !sck_q) begin
         rx_sr_d = {rx_sr_q[PIXEL_BITS-2:0], spi_sdi_i};
      end
      if (done_d) begin
         rx_px_d = rx_sr_q;
      end
      sdo_d = (state_q != ST_IDLE) ? tx_sr_d[PIXEL_BITS-1] : 1'b0;
`ifdef SPI_MASTER_PXRDY_EN
      px_rdy_d = done_q;
`else
      px_rdy_d = 1'b0;
`endif
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rx_px_o   = rx_px_q;
   assign spi_sck_o = sck_q;
   assign spi_cs_o  = cs_q;
   assign spi_sdo_o = sdo_q;
   assign px_rdy_o  = px_rdy_q;

endmodule

// File: tb/tb_spi_pixel_master.sv
// Bench for spi_pixel_master: two instances (CLK_DIV 2 and 1) checked every cycle against a
// frame-timing model derived from accept time, plus directed literal checks.
`timescale 1ns/1ps
module tb_spi_pixel_master;
   localparam int P  = 24;
   localparam int D0 = 2;
   localparam int D1 = 1;
`ifdef SPI_MASTER_PXRDY_EN
   localparam bit PXR_EN = 1'b1;
`else
   localparam bit PXR_EN = 1'b0;
`endif

   logic         clk;
   logic         nreset;
   logic         start;
   logic [P-1:0] tx_px;
   logic [1:0]   busy_w, done_w, sck_w, cs_w, sdo_w, pxr_w, sdi_w;
   logic [P-1:0] rx_w [2];
   logic [1:0]   sdi_drv;
   logic [1:0]   sck_prev;
   int           mode [2];   // 0 loopback, 1 MISO tied 1, 2 random MISO, 3 slave model
   int           scnt [2];
   logic [P-1:0] slv;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   bit           act    [2];
   int           t0     [2];
   int           pxr_t  [2];
   logic [P-1:0] txw    [2];
   logic [P-1:0] rxw    [2];
   logic [P-1:0] rx_exp [2];

   assign sdi_w[0] = (mode[0] == 0) ? sdo_w[0] : sdi_drv[0];
   assign sdi_w[1] = (mode[1] == 0) ? sdo_w[1] : sdi_drv[1];

   spi_pixel_master #(.PIXEL_BITS(P), .CLK_DIV(D0)) u_dut0 (
      .clk_i(clk), .nreset_i(nreset), .start_i(start), .tx_px_i(tx_px),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .rx_px_o(rx_w[0]),
      .spi_sck_o(sck_w[0]), .spi_cs_o(cs_w[0]), .spi_sdo_o(sdo_w[0]),
      .spi_sdi_i(sdi_w[0]), .px_rdy_o(pxr_w[0])
   );

   spi_pixel_master #(.PIXEL_BITS(P), .CLK_DIV(D1)) u_dut1 (
      .clk_i(clk), .nreset_i(nreset), .start_i(start), .tx_px_i(tx_px),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .rx_px_o(rx_w[1]),
      .spi_sck_o(sck_w[1]), .spi_cs_o(cs_w[1]), .spi_sdo_o(sdo_w[1]),
      .spi_sdi_i(sdi_w[1]), .px_rdy_o(pxr_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int dv(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   // Model step at each rising clk edge: frame bookkeeping from accept time only.
   task automatic model_edge();
      int d, k, j;
      logic b;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!nreset) begin
            act[i]    = 1'b0;
            rx_exp[i] = '0;
            pxr_t[i]  = 0;
         end else begin
            d = dv(i);
            if (act[i] && (cyc - t0[i] >= (2*P+3)*d + 1)) act[i] = 1'b0;
            if (!act[i] && start) begin
               act[i] = 1'b1;
               t0[i]  = cyc;
               txw[i] = tx_px;
               rxw[i] = '0;
            end else if (act[i]) begin
               k = cyc - t0[i];
               if (k >= 1+d && ((k-1-d) % (2*d)) == 0 && ((k-1-d) / (2*d)) < P) begin
                  j = (k-1-d) / (2*d);
                  b = (mode[i] == 0) ? txw[i][P-1-j] : sdi_drv[i];
                  rxw[i] = {rxw[i][P-2:0], b};
               end
               if (k == 1 + (2*P+2)*d) begin
                  rx_exp[i] = rxw[i];
                  pxr_t[i]  = cyc + 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      int d, k, j;
      bit ebusy, ecsl, esck, edone, epxr;
      if (!nreset) return;
      for (int i = 0; i < 2; i++) begin
         d     = dv(i);
         k     = cyc - t0[i];
         ebusy = act[i] && k >= 1 && k < 1 + (2*P+3)*d;
         ecsl  = act[i] && k >= 1 && k < 1 + (2*P+2)*d;
         esck  = act[i] && k >= 1+d && (k-1-d) < 2*P*d && (((k-1-d)/d) % 2) == 0;
         edone = act[i] && k == 1 + (2*P+2)*d;
         epxr  = PXR_EN && (cyc == pxr_t[i]);
         chk($sformatf("busy%0d", i), busy_w[i], ebusy);
         chk($sformatf("cs%0d", i), cs_w[i], !ecsl);
         chk($sformatf("sck%0d", i), sck_w[i], esck);
         chk($sformatf("done%0d", i), done_w[i], edone);
         chk($sformatf("pxrdy%0d", i), pxr_w[i], epxr);
         chk($sformatf("rx%0d", i), rx_w[i], rx_exp[i]);
         if (ecsl) begin
            j = (k-1) / (2*d);
            if (j > P-1) j = P-1;
            chk($sformatf("sdo%0d", i), sdo_w[i], txw[i][P-1-j]);
         end
      end
   endtask

   task automatic drive_sdi();
      for (int i = 0; i < 2; i++) begin
         if (cs_w[i]) scnt[i] = 0;
         else if (sck_w[i] && !sck_prev[i]) scnt[i]++;
         sck_prev[i] = sck_w[i];
         case (mode[i])
            1:       sdi_drv[i] = 1'b1;
            2:       sdi_drv[i] = 1'($urandom);
            3:       sdi_drv[i] = (scnt[i] < P) ? slv[P-1-scnt[i]] : 1'b0;
            default: sdi_drv[i] = 1'b0;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      drive_sdi();
   endtask

   task automatic frame(input int i, input logic [P-1:0] w, output int dlat, output int rises,
                        output int cslow, output logic [P-1:0] mosi);
      int  acc;
      bit  got;
      logic sp;
      dlat = 0; rises = 0; cslow = 0; mosi = '0; got = 1'b0; sp = 1'b0;
      tx_px = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      acc   = cyc;
      tx_px = P'($urandom);
      for (int n = 0; n < 600 && !got; n++) begin
         tick();
         if (sck_w[i] && !sp) begin
            rises++;
            mosi = {mosi[P-2:0], sdo_w[i]};
         end
         sp = sck_w[i];
         if (!cs_w[i]) cslow++;
         if (done_w[i]) begin
            dlat = cyc - acc;
            got  = 1'b1;
         end
      end
      if (!got) chk($sformatf("frame%0d_done_seen", i), 32'd0, 32'd1);
   endtask

   initial begin
      int dlat, rises, cslow, nf, last, run, mingap, r, n;
      logic [P-1:0] mosi;
      logic csprev, sp;
      nreset = 1'b0; start = 1'b0; tx_px = '0; slv = '0;
      sdi_drv = '0; sck_prev = '0;
      mode[0] = 0; mode[1] = 0; scnt[0] = 0; scnt[1] = 0;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; t0[i] = 0; pxr_t[i] = 0; txw[i] = '0; rxw[i] = '0; rx_exp[i] = '0;
      end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_cs", cs_w[i], 1);
         chk("reset_sck", sck_w[i], 0);
         chk("reset_sdo", sdo_w[i], 0);
         chk("reset_busy", busy_w[i], 0);
         chk("reset_done", done_w[i], 0);
         chk("reset_pxrdy", pxr_w[i], 0);
         chk("reset_rx", rx_w[i], 0);
      end
      repeat (2) tick();
      nreset = 1'b1;
      repeat (4) tick();

      // loopback, CLK_DIV=2
      frame(0, 24'hA5C3F0, dlat, rises, cslow, mosi);
      chk("lb2_rx", rx_w[0], 24'hA5C3F0);
      chk("lb2_done_latency", dlat, 101);
      chk("lb2_sck_rises", rises, 24);
      chk("lb2_cs_low_cycles", cslow, 100);
      chk("lb2_mosi", mosi, 24'hA5C3F0);
      repeat (110) tick();

      // loopback, CLK_DIV=1
      frame(1, 24'h5A5A5A, dlat, rises, cslow, mosi);
      chk("lb1_rx", rx_w[1], 24'h5A5A5A);
      chk("lb1_done_latency", dlat, 51);
      chk("lb1_sck_rises", rises, 24);
      chk("lb1_cs_low_cycles", cslow, 50);
      repeat (110) tick();

      // MISO tied high
      mode[0] = 1;
      frame(0, 24'h000001, dlat, rises, cslow, mosi);
      chk("miso1_rx", rx_w[0], 24'hFFFFFF);
      chk("miso1_mosi", mosi, 24'h000001);
      repeat (110) tick();

      // slave returning a fixed word
      mode[0] = 3; slv = 24'h123456;
      frame(0, 24'hC0FFEE, dlat, rises, cslow, mosi);
      chk("slave_rx", rx_w[0], 24'h123456);
      chk("slave_mosi", mosi, 24'hC0FFEE);
      tick();
      chk("slave_pxrdy_after_done", pxr_w[0], PXR_EN);
      repeat (110) tick();

      // start held high: back-to-back frames
      mode[0] = 2; mode[1] = 2;
      nf = 0; last = 0; run = 0; mingap = 1000; csprev = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tx_px = P'($urandom);
         tick();
         if (!cs_w[0] && csprev) begin
            if (nf > 0) begin
               chk("b2b_period", cyc - last, (2*P+3)*D0 + 1);
               if (run < mingap) mingap = run;
            end
            last = cyc;
            nf++;
         end
         run    = cs_w[0] ? run + 1 : 0;
         csprev = cs_w[0];
      end
      start = 1'b0;
      chk("b2b_frames", nf, 3);
      chk("b2b_cs_gap_ge2", (mingap >= 2), 1);
      repeat (110) tick();

      // reset at the 10th SCK rise
      mode[0] = 0; mode[1] = 0;
      tx_px = P'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      r = 0; n = 0; sp = 1'b0;
      while (r < 10 && n < 200) begin
         tick();
         if (sck_w[0] && !sp) r++;
         sp = sck_w[0];
         n++;
      end
      chk("rst_reached_rise10", r, 10);
      nreset = 1'b0;
      #1;
      chk("rst_cs", cs_w[0], 1);
      chk("rst_sck", sck_w[0], 0);
      chk("rst_rx", rx_w[0], 0);
      chk("rst_busy", busy_w[0], 0);
      chk("rst_done", done_w[0], 0);
      chk("rst_pxrdy", pxr_w[0], 0);
      repeat (3) tick();
      nreset = 1'b1;
      tick();
      frame(0, 24'h3C5A96, dlat, rises, cslow, mosi);
      chk("post_rst_rx", rx_w[0], 24'h3C5A96);
      chk("post_rst_latency", dlat, 101);
      repeat (110) tick();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         start = ($urandom % 5) == 0;
         tx_px = P'($urandom);
         if (k % 500 == 0) begin
            mode[0] = ($urandom % 2 == 0) ? 0 : 2;
            mode[1] = ($urandom % 2 == 0) ? 0 : 2;
         end
         tick();
      end
      start = 1'b0;
      repeat (110) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
